// File: rtl/snoop_cache_ctrl_if.sv
// Processor-side and bus-side signal bundle of one snooping cache.
// The slave modport is the cache itself; the master modport is its environment (processor, arbiter, memory, other caches).
`timescale 1ns/1ps
interface snoop_cache_ctrl_if #(
  parameter int ID_W   = 2,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [DATA_W-1:0] rsp_rdata;
  logic              bus_req;
  logic              bus_gnt;
  logic [1:0]        bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rdata_valid;
  logic [DATA_W-1:0] bus_rdata;
  logic              snoop_valid;
  logic [ID_W-1:0]   snoop_src;
  logic [1:0]        snoop_cmd;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_shared;
  logic              flush_valid;
  logic [ADDR_W-1:0] flush_addr;
  logic [DATA_W-1:0] flush_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output bus_gnt, bus_rdata_valid, bus_rdata,
    output snoop_valid, snoop_src, snoop_cmd, snoop_addr, snoop_shared,
    input  req_ready, rsp_valid, rsp_hit, rsp_rdata,
    input  bus_req, bus_cmd, bus_addr, bus_wdata,
    input  flush_valid, flush_addr, flush_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  bus_gnt, bus_rdata_valid, bus_rdata,
    input  snoop_valid, snoop_src, snoop_cmd, snoop_addr, snoop_shared,
    output req_ready, rsp_valid, rsp_hit, rsp_rdata,
    output bus_req, bus_cmd, bus_addr, bus_wdata,
    output flush_valid, flush_addr, flush_data
  );
endinterface

// File: rtl/snoop_cache_ctrl.sv
// Direct-mapped, one-word-per-line MSI snooping cache on a shared atomic bus.
// Define MESI_EN to add the Exclusive state (clean-unshared fills, silent E->M store upgrade).
`timescale 1ns/1ps
module snoop_cache_ctrl #(
  parameter int PROC_ID = 0,
  parameter int ID_W    = 2,
  parameter int INDEX_W = 1,
  parameter int TAG_W   = 1,
  parameter int DATA_W  = 4
) (
  input logic               clk,
  input logic               rst,
  snoop_cache_ctrl_if.slave bus
);
  localparam int ADDR_W = TAG_W + INDEX_W;
  localparam int LINES  = 2 ** INDEX_W;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_RD    = 2'b01;
  localparam logic [1:0] CMD_RDX   = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;

  typedef enum logic [1:0] {LS_I, LS_S, LS_E, LS_M} line_t;
  typedef enum logic [2:0] {ST_IDLE, ST_WB, ST_MISS, ST_FILL, ST_RESP} state_t;

  line_t             r_line [LINES];
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  state_t            r_state;
  state_t            w_state_next;
  logic              r_req_we;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_hit_rsp;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_flush_valid;
  logic [ADDR_W-1:0] r_flush_addr;
  logic [DATA_W-1:0] r_flush_data;

  logic [INDEX_W-1:0] w_req_idx, w_snp_idx, w_miss_idx;
  logic [TAG_W-1:0]   w_req_tag, w_snp_tag, w_miss_tag;
  line_t              w_req_line, w_snp_line, w_fill_state;
  logic               w_req_present, w_snp_present, w_snp_hit;
  logic               w_store_ok, w_hit, w_victim_dirty, w_accept;
  logic               w_req_ready, w_bus_req;
  logic [1:0]         w_bus_cmd;
  logic [ADDR_W-1:0]  w_bus_addr;
  logic [DATA_W-1:0]  w_bus_wdata;

  assign w_req_idx  = bus.req_addr[INDEX_W-1:0];
  assign w_req_tag  = bus.req_addr[ADDR_W-1:INDEX_W];
  assign w_snp_idx  = bus.snoop_addr[INDEX_W-1:0];
  assign w_snp_tag  = bus.snoop_addr[ADDR_W-1:INDEX_W];
  assign w_miss_idx = r_req_addr[INDEX_W-1:0];
  assign w_miss_tag = r_req_addr[ADDR_W-1:INDEX_W];
  assign w_req_line = r_line[w_req_idx];
  assign w_snp_line = r_line[w_snp_idx];

  assign w_req_present = (w_req_line != LS_I) && (r_tag[w_req_idx] == w_req_tag);
  assign w_snp_present = (w_snp_line != LS_I) && (r_tag[w_snp_idx] == w_snp_tag);

  // Snoops are only legal while we do not own the bus (IDLE, or RESP after bus_req dropped).
  assign w_snp_hit = bus.snoop_valid && (bus.snoop_src != ID_W'(PROC_ID)) && w_snp_present &&
                     ((r_state == ST_IDLE) || (r_state == ST_RESP));

`ifdef MESI_EN
  assign w_store_ok   = (w_req_line == LS_M) || (w_req_line == LS_E);
  assign w_fill_state = bus.snoop_shared ? LS_S : LS_E;
`else
  logic w_unused_shared;
  assign w_store_ok      = (w_req_line == LS_M);
  assign w_fill_state    = LS_S;
  assign w_unused_shared = bus.snoop_shared;
`endif

  assign w_hit          = w_req_present && (!bus.req_we || w_store_ok);
  assign w_victim_dirty = !w_req_present && (w_req_line == LS_M);
  assign w_accept       = bus.req_valid && w_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_bus_req    = 1'b0;
    w_bus_cmd    = CMD_NONE;
    w_bus_addr   = '0;
    w_bus_wdata  = '0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = !w_snp_hit;
        if (w_accept && !w_hit) w_state_next = w_victim_dirty ? ST_WB : ST_MISS;
      end
      ST_WB: begin
        w_bus_req = 1'b1;
        if (bus.bus_gnt) begin
          w_bus_cmd    = CMD_FLUSH;
          w_bus_addr   = {r_tag[w_miss_idx], w_miss_idx};
          w_bus_wdata  = r_data[w_miss_idx];
          w_state_next = ST_MISS;
        end
      end
      ST_MISS: begin
        // Grant stays high from WB onward; leaving MISS on the grant cycle keeps the command one cycle wide.
        w_bus_req = 1'b1;
        if (bus.bus_gnt) begin
          w_bus_cmd    = r_req_we ? CMD_RDX : CMD_RD;
          w_bus_addr   = r_req_addr;
          w_state_next = r_req_we ? ST_RESP : ST_FILL;
        end
      end
      ST_FILL: begin
        w_bus_req = 1'b1;
        if (bus.bus_rdata_valid) w_state_next = ST_RESP;
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        r_line[i] <= LS_I;
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_snp_hit) begin
        if (bus.snoop_cmd == CMD_RDX) r_line[w_snp_idx] <= LS_I;
        else if ((bus.snoop_cmd == CMD_RD) && (w_snp_line == LS_M)) r_line[w_snp_idx] <= LS_S;
`ifdef MESI_EN
        else if ((bus.snoop_cmd == CMD_RD) && (w_snp_line == LS_E)) r_line[w_snp_idx] <= LS_S;
`endif
      end
      if (w_accept && w_hit && bus.req_we) begin
        r_line[w_req_idx] <= LS_M;
        r_data[w_req_idx] <= bus.req_wdata;
      end
      if ((r_state == ST_WB) && bus.bus_gnt) r_line[w_miss_idx] <= LS_I;
      // A store owns the whole word, so BusRdX needs no fill data.
      if ((r_state == ST_MISS) && bus.bus_gnt && r_req_we) begin
        r_line[w_miss_idx] <= LS_M;
        r_tag[w_miss_idx]  <= w_miss_tag;
        r_data[w_miss_idx] <= r_req_wdata;
      end
      if ((r_state == ST_FILL) && bus.bus_rdata_valid) begin
        r_line[w_miss_idx] <= w_fill_state;
        r_tag[w_miss_idx]  <= w_miss_tag;
        r_data[w_miss_idx] <= bus.bus_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_we      <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_hit_rsp     <= 1'b0;
      r_rsp_rdata   <= '0;
      r_flush_valid <= 1'b0;
      r_flush_addr  <= '0;
      r_flush_data  <= '0;
    end else begin
      if (w_accept) begin
        r_req_we    <= bus.req_we;
        r_req_addr  <= bus.req_addr;
        r_req_wdata <= bus.req_wdata;
      end
      r_hit_rsp <= w_accept && w_hit;
      if (w_accept && w_hit && !bus.req_we) r_rsp_rdata <= r_data[w_req_idx];
      else if ((r_state == ST_FILL) && bus.bus_rdata_valid) r_rsp_rdata <= bus.bus_rdata;
      r_flush_valid <= w_snp_hit && (w_snp_line == LS_M) &&
                       ((bus.snoop_cmd == CMD_RD) || (bus.snoop_cmd == CMD_RDX));
      if (w_snp_hit) begin
        r_flush_addr <= bus.snoop_addr;
        r_flush_data <= r_data[w_snp_idx];
      end
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = r_hit_rsp || (r_state == ST_RESP);
  assign bus.rsp_hit     = r_hit_rsp;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.bus_req     = w_bus_req;
  assign bus.bus_cmd     = w_bus_cmd;
  assign bus.bus_addr    = w_bus_addr;
  assign bus.bus_wdata   = w_bus_wdata;
  assign bus.flush_valid = r_flush_valid;
  assign bus.flush_addr  = r_flush_addr;
  assign bus.flush_data  = r_flush_data;
endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Bench for snoop_cache_ctrl: directed scenarios then random loads/stores/snoops against a coherence-level reference model.
`timescale 1ns/1ps
module tb_snoop_cache_ctrl;
  localparam int PROC_ID = 0;
  localparam int ID_W    = 2;
  localparam int INDEX_W = 1;
  localparam int TAG_W   = 1;
  localparam int DATA_W  = 4;
  localparam int ADDR_W  = TAG_W + INDEX_W;
  localparam int LINES   = 1 << INDEX_W;
  localparam int NADDR   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snoop_cache_ctrl_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  snoop_cache_ctrl #(
    .PROC_ID(PROC_ID), .ID_W(ID_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: per line the held address and coherence state (0 I, 1 S, 2 E, 3 M);
  // golden = architecturally latest value per address, mem = backing memory.
  int m_st   [LINES];
  int m_addr [LINES];
  int golden [NADDR];
  int mem    [NADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_st[i]   = 0;
      m_addr[i] = 0;
    end
    for (int a = 0; a < NADDR; a++) golden[a] = mem[a];
  endtask

  task automatic do_req(input int we, input int addr, input int wdata, input int gd, input int fd, input int sh);
    int idx, vaddr, gcnt, fcnt, last;
    bit held, hit, wb, granted, fill_pending, got_rsp;
    int cmds[$];
    int caddr[$];
    int cdata[$];
    logic obs_hit;
    logic [DATA_W-1:0] obs_rdata;
    idx   = addr % LINES;
    vaddr = m_addr[idx];
    held  = (m_st[idx] != 0) && (m_addr[idx] == addr);
    hit   = held && ((we == 0) || (m_st[idx] >= 2));
    wb    = !held && (m_st[idx] == 3);
    obs_hit   = 1'b0;
    obs_rdata = '0;
    got_rsp   = 1'b0;

    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we[0];
    bus_if.req_addr  = ADDR_W'(addr);
    bus_if.req_wdata = DATA_W'(wdata);
    #1 chk("req_ready", bus_if.req_ready, 1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;

    if (hit) begin
      chk("hit_rsp_valid", bus_if.rsp_valid, 1);
      chk("hit_rsp_hit", bus_if.rsp_hit, 1);
      chk("hit_bus_req", bus_if.bus_req, 0);
      if (we == 0) chk("hit_rdata", bus_if.rsp_rdata, golden[addr]);
      else begin
        golden[addr] = wdata;
        m_st[idx]    = 3;
      end
    end else begin
      granted = 1'b0; fill_pending = 1'b0; gcnt = 0; fcnt = 0;
      for (int cyc = 0; cyc < 60 && !got_rsp; cyc++) begin
        bus_if.bus_rdata_valid = 1'b0;
        if (!bus_if.bus_req) begin
          bus_if.bus_gnt = 1'b0; granted = 1'b0; gcnt = 0;
        end else if (granted || gcnt >= gd) begin
          bus_if.bus_gnt = 1'b1; granted = 1'b1;
        end else begin
          bus_if.bus_gnt = 1'b0; gcnt++;
        end
        if (fill_pending) begin
          if (fcnt >= fd) begin
            bus_if.bus_rdata_valid = 1'b1;
            bus_if.bus_rdata       = DATA_W'(mem[addr]);
            bus_if.snoop_shared    = sh[0];
            fill_pending = 1'b0;
          end else fcnt++;
        end
        #1;
        if (bus_if.bus_cmd != 2'b00) begin
          cmds.push_back(int'(bus_if.bus_cmd));
          caddr.push_back(int'(bus_if.bus_addr));
          cdata.push_back(int'(bus_if.bus_wdata));
          if (bus_if.bus_cmd == 2'b01) begin fill_pending = 1'b1; fcnt = 0; end
        end
        if (bus_if.rsp_valid) begin
          got_rsp   = 1'b1;
          obs_hit   = bus_if.rsp_hit;
          obs_rdata = bus_if.rsp_rdata;
        end
        @(posedge clk);
        #1;
      end
      bus_if.bus_gnt         = 1'b0;
      bus_if.bus_rdata_valid = 1'b0;
      bus_if.snoop_shared    = 1'b0;

      chk("miss_rsp_seen", got_rsp, 1);
      chk("miss_rsp_hit", obs_hit, 0);
      chk("miss_ncmd", cmds.size(), wb ? 2 : 1);
      if (wb && cmds.size() >= 1) begin
        chk("wb_cmd", cmds[0], 3);
        chk("wb_addr", caddr[0], vaddr);
        chk("wb_data", cdata[0], golden[vaddr]);
        mem[vaddr] = golden[vaddr];
      end
      if (cmds.size() >= 1) begin
        last = cmds.size() - 1;
        chk("miss_cmd", cmds[last], (we != 0) ? 2 : 1);
        chk("miss_addr", caddr[last], addr);
      end
      if (we == 0) chk("miss_rdata", obs_rdata, golden[addr]);
      m_addr[idx] = addr;
      if (we != 0) begin
        m_st[idx]    = 3;
        golden[addr] = wdata;
      end else begin
`ifdef MESI_EN
        m_st[idx] = (sh != 0) ? 1 : 2;
`else
        m_st[idx] = 1;
`endif
      end
    end
    $display("req  we=%0d addr=%0h wdata=%0h hit=%0d wb=%0d", we, addr, wdata, hit, wb);
  endtask

  task automatic do_snoop(input int src, input int cmd, input int addr);
    int idx;
    bit held, hitv, exp_fl;
    idx    = addr % LINES;
    held   = (m_st[idx] != 0) && (m_addr[idx] == addr);
    hitv   = (src != PROC_ID) && held;
    exp_fl = hitv && (m_st[idx] == 3) && (cmd == 1 || cmd == 2);

    @(negedge clk);
    bus_if.snoop_valid = 1'b1;
    bus_if.snoop_src   = ID_W'(src);
    bus_if.snoop_cmd   = 2'(cmd);
    bus_if.snoop_addr  = ADDR_W'(addr);
    #1 chk("snoop_req_ready", bus_if.req_ready, !hitv);
    @(posedge clk);
    #1 bus_if.snoop_valid = 1'b0;
    chk("flush_valid", bus_if.flush_valid, exp_fl);
    if (exp_fl) begin
      chk("flush_addr", bus_if.flush_addr, addr);
      chk("flush_data", bus_if.flush_data, golden[addr]);
      mem[addr] = golden[addr];
    end
    if (hitv && cmd == 2) m_st[idx] = 0;
    else if (hitv && cmd == 1 && m_st[idx] >= 2) m_st[idx] = 1;
    // Another agent's BusRdX means it now writes a fresh value to that address.
    if (src != PROC_ID && cmd == 2) begin
      golden[addr] = $urandom_range(0, 15);
      mem[addr]    = golden[addr];
    end
    $display("snp  src=%0d cmd=%0d addr=%0h hit=%0d flush=%0d", src, cmd, addr, hitv, exp_fl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req_valid       = 1'b0;
    bus_if.req_we          = 1'b0;
    bus_if.req_addr        = '0;
    bus_if.req_wdata       = '0;
    bus_if.bus_gnt         = 1'b0;
    bus_if.bus_rdata_valid = 1'b0;
    bus_if.bus_rdata       = '0;
    bus_if.snoop_valid     = 1'b0;
    bus_if.snoop_src       = '0;
    bus_if.snoop_cmd       = '0;
    bus_if.snoop_addr      = '0;
    bus_if.snoop_shared    = 1'b0;
    for (int a = 0; a < NADDR; a++) mem[a] = $urandom_range(0, 15);
    mem[2] = 9;
    model_reset();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus_if.req_ready, 1);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_rsp_hit", bus_if.rsp_hit, 0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
    chk("rst_bus_req", bus_if.bus_req, 0);
    chk("rst_bus_cmd", bus_if.bus_cmd, 0);
    chk("rst_bus_addr", bus_if.bus_addr, 0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 0);
    chk("rst_flush_valid", bus_if.flush_valid, 0);
    chk("rst_flush_addr", bus_if.flush_addr, 0);
    chk("rst_flush_data", bus_if.flush_data, 0);
    @(negedge clk);
    rst = 1'b0;

    do_req(0, 2, 0, 1, 1, 1);   // cold LOAD miss, fill 9
    do_req(0, 2, 0, 0, 0, 1);   // LOAD hit
    do_req(1, 2, 5, 0, 0, 1);   // STORE on S: BusRdX upgrade
    do_snoop(1, 1, 2);          // BusRd on M: flush 5, line S
    do_req(1, 0, 7, 0, 0, 1);   // line 0 takes addr 0 as M (clean victim)
    do_req(1, 2, 3, 1, 0, 1);   // dirty victim: Flush 0x0 then BusRdX 0x2
    do_req(0, 2, 0, 0, 0, 1);   // hit with 3
    do_snoop(0, 2, 2);          // own ID: ignored
    do_req(0, 2, 0, 0, 0, 1);   // still M hit
    do_snoop(2, 2, 2);          // BusRdX on M: flush, line I
    do_req(0, 2, 0, 2, 2, 1);   // misses again
`ifdef MESI_EN
    do_req(0, 3, 0, 0, 0, 0);   // unshared fill -> E
    do_req(1, 3, 10, 0, 0, 0);  // silent E->M
`endif

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0)
        do_snoop($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, NADDR - 1));
      else
        do_req($urandom_range(0, 1), $urandom_range(0, NADDR - 1), $urandom_range(0, 15),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    // Reset while a BusRd is on the bus.
    do_snoop(1, 2, 1);
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = ADDR_W'(1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    chk("midrst_bus_req_before", bus_if.bus_req, 1);
    bus_if.bus_gnt = 1'b1;
    #1 chk("midrst_bus_cmd_before", bus_if.bus_cmd, 1);
    rst = 1'b1;
    #1;
    chk("midrst_bus_req", bus_if.bus_req, 0);
    chk("midrst_bus_cmd", bus_if.bus_cmd, 0);
    chk("midrst_req_ready", bus_if.req_ready, 1);
    chk("midrst_rsp_valid", bus_if.rsp_valid, 0);
    bus_if.bus_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1 chk("postrst_rsp_valid", bus_if.rsp_valid, 0);
    end
    do_req(0, 1, 0, 0, 1, 1);
    do_req(0, 0, 0, 1, 0, 1);
    do_req(0, 1, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
